// File: rtl/snoopy_bus_arbiter.sv
// snoopy_bus_arbiter: responder end of the snoopy lock bus.
// Grants one coherence controller at a time (round-robin).
// Compares the owner's key against every other controller's exported lock table.
// Holds the one-bit conflict result until the owner releases the bus.
// Optional build macro SNOOPY_ARB_STATS_EN adds saturating grant/conflict/timeout counters.
module snoopy_bus_arbiter #(
    parameter int unsigned NUM_PROCS     = 4,
    parameter int unsigned MAX_LOCK_KEYS = 4,
    parameter int unsigned GRANT_TIMEOUT = 32
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUM_PROCS-1:0]                  bus_request,
    input  logic [NUM_PROCS-1:0]                  bus_release,
    input  logic [NUM_PROCS-1:0]                  snoop_check_req,
    input  logic [32*NUM_PROCS-1:0]               bus_key_flat,
    input  logic [32*NUM_PROCS*MAX_LOCK_KEYS-1:0] locked_key_flat,
    output logic [NUM_PROCS-1:0]                  bus_grant,
    output logic [NUM_PROCS-1:0]                  add_conflict
`ifdef SNOOPY_ARB_STATS_EN
    ,
    output logic [31:0]                           stat_grants,
    output logic [31:0]                           stat_conflicts,
    output logic [15:0]                           stat_timeouts
`endif
);

    localparam int unsigned     IdxW     = $clog2(NUM_PROCS);
    localparam int unsigned     CntW     = $clog2(GRANT_TIMEOUT);
    localparam logic [CntW-1:0] CntLast  = CntW'(GRANT_TIMEOUT - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_PROCS - 1);
    // All-ones marks an unused lock-table slot; it must never report a match.
    localparam logic [31:0]     EmptyKey = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StArbIdle,
        StGranted,
        StHold
    } state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       owner_q, owner_d;
    logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [NUM_PROCS-1:0]  bus_grant_q, bus_grant_d;
    logic [NUM_PROCS-1:0]  add_conflict_q, add_conflict_d;

    logic                  req_found;
    logic [IdxW-1:0]       req_idx;
    logic [IdxW-1:0]       cand_idx;
    logic [IdxW-1:0]       owner_inc;
    logic [31:0]           owner_key;
    logic [31:0]           entry;
    logic                  conflict;

    // Round-robin pick: first requester at or after rr_ptr.
    always_comb begin
        req_found = 1'b0;
        req_idx   = rr_ptr_q;
        cand_idx  = rr_ptr_q;
        for (int i = 0; i < int'(NUM_PROCS); i++) begin
            cand_idx = IdxW'((int'(rr_ptr_q) + i) % int'(NUM_PROCS));
            if (!req_found && bus_request[cand_idx]) begin
                req_found = 1'b1;
                req_idx   = cand_idx;
            end
        end
    end

    // Owner key against every non-owner table entry; the owner's own table is skipped.
    always_comb begin
        owner_key = '0;
        for (int p = 0; p < int'(NUM_PROCS); p++) begin
            if (owner_q == IdxW'(p)) begin
                owner_key = bus_key_flat[32*p +: 32];
            end
        end
        conflict = 1'b0;
        entry    = '0;
        for (int p = 0; p < int'(NUM_PROCS); p++) begin
            for (int k = 0; k < int'(MAX_LOCK_KEYS); k++) begin
                entry = locked_key_flat[32*(p*int'(MAX_LOCK_KEYS)+k) +: 32];
                if ((owner_q != IdxW'(p)) && (entry == owner_key) && (entry != EmptyKey)) begin
                    conflict = 1'b1;
                end
            end
        end
    end

    assign owner_inc = (owner_q == IdxLast) ? '0 : owner_q + 1'b1;

    // Tenure FSM: next state, registered grant and conflict outputs.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        rr_ptr_d       = rr_ptr_q;
        cnt_d          = cnt_q;
        bus_grant_d    = bus_grant_q;
        add_conflict_d = add_conflict_q;
        unique case (state_q)
            StArbIdle: begin
                bus_grant_d    = '0;
                add_conflict_d = '0;
                if (req_found) begin
                    owner_d              = req_idx;
                    bus_grant_d[req_idx] = 1'b1;
                    cnt_d                = '0;
                    state_d              = StGranted;
                end
            end
            StGranted: begin
                if (snoop_check_req[owner_q]) begin
                    bus_grant_d             = '0;
                    add_conflict_d          = '0;
                    add_conflict_d[owner_q] = conflict;
                    state_d                 = StHold;
                end else if (cnt_q == CntLast) begin
                    // Revoke a stale grant so a forgotten request cannot starve the bus.
                    bus_grant_d = '0;
                    rr_ptr_d    = owner_inc;
                    state_d     = StArbIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHold: begin
                if (bus_release[owner_q]) begin
                    add_conflict_d = '0;
                    rr_ptr_d       = owner_inc;
                    state_d        = StArbIdle;
                end
            end
            default: begin
                bus_grant_d    = '0;
                add_conflict_d = '0;
                state_d        = StArbIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= StArbIdle;
            owner_q        <= '0;
            rr_ptr_q       <= '0;
            cnt_q          <= '0;
            bus_grant_q    <= '0;
            add_conflict_q <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            rr_ptr_q       <= rr_ptr_d;
            cnt_q          <= cnt_d;
            bus_grant_q    <= bus_grant_d;
            add_conflict_q <= add_conflict_d;
        end
    end

    assign bus_grant    = bus_grant_q;
    assign add_conflict = add_conflict_q;

`ifdef SNOOPY_ARB_STATS_EN
    logic        grant_evt, conflict_evt, timeout_evt;
    logic [31:0] stat_grants_q, stat_grants_d;
    logic [31:0] stat_conflicts_q, stat_conflicts_d;
    logic [15:0] stat_timeouts_q, stat_timeouts_d;

    assign grant_evt    = (state_q == StArbIdle) && req_found;
    assign conflict_evt = (state_q == StGranted) && snoop_check_req[owner_q] && conflict;
    assign timeout_evt  = (state_q == StGranted) && !snoop_check_req[owner_q] && (cnt_q == CntLast);

    // Saturating event counters.
    always_comb begin
        stat_grants_d    = stat_grants_q;
        stat_conflicts_d = stat_conflicts_q;
        stat_timeouts_d  = stat_timeouts_q;
        if (grant_evt && (stat_grants_q != '1)) begin
            stat_grants_d = stat_grants_q + 32'd1;
        end
        if (conflict_evt && (stat_conflicts_q != '1)) begin
            stat_conflicts_d = stat_conflicts_q + 32'd1;
        end
        if (timeout_evt && (stat_timeouts_q != '1)) begin
            stat_timeouts_d = stat_timeouts_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_grants_q    <= '0;
            stat_conflicts_q <= '0;
            stat_timeouts_q  <= '0;
        end else begin
            stat_grants_q    <= stat_grants_d;
            stat_conflicts_q <= stat_conflicts_d;
            stat_timeouts_q  <= stat_timeouts_d;
        end
    end

    assign stat_grants    = stat_grants_q;
    assign stat_conflicts = stat_conflicts_q;
    assign stat_timeouts  = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// Bench for snoopy_bus_arbiter: table vectors, hand sequences and random traffic,
// every cycle compared against a transaction-level reference model.
module tb_snoopy_bus_arbiter;

    localparam int NP = 4;
    localparam int NK = 4;
    localparam int TO = 32;

    logic                clk;
    logic                reset_n;
    logic [NP-1:0]       bus_request;
    logic [NP-1:0]       bus_release;
    logic [NP-1:0]       snoop_check_req;
    logic [32*NP-1:0]    bus_key_flat;
    logic [32*NP*NK-1:0] locked_key_flat;
    logic [NP-1:0]       bus_grant;
    logic [NP-1:0]       add_conflict;
`ifdef SNOOPY_ARB_STATS_EN
    logic [31:0]         stat_grants;
    logic [31:0]         stat_conflicts;
    logic [15:0]         stat_timeouts;
`endif

    logic [31:0] key [NP];
    logic [31:0] tab [NP][NK];
    logic [31:0] pool [5];

    for (genvar p = 0; p < NP; p++) begin : g_key
        assign bus_key_flat[32*p +: 32] = key[p];
        for (genvar k = 0; k < NK; k++) begin : g_tab
            assign locked_key_flat[32*(p*NK+k) +: 32] = tab[p][k];
        end
    end

    snoopy_bus_arbiter #(
        .NUM_PROCS    (NP),
        .MAX_LOCK_KEYS(NK),
        .GRANT_TIMEOUT(TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus_request    (bus_request),
        .bus_release    (bus_release),
        .snoop_check_req(snoop_check_req),
        .bus_key_flat   (bus_key_flat),
        .locked_key_flat(locked_key_flat),
        .bus_grant      (bus_grant),
        .add_conflict   (add_conflict)
`ifdef SNOOPY_ARB_STATS_EN
        ,
        .stat_grants    (stat_grants),
        .stat_conflicts (stat_conflicts),
        .stat_timeouts  (stat_timeouts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: who owns the bus, whether the grant or the result is showing,
    // how long the grant has been idle, and which processor has top priority next.
    int            m_owner    = -1;
    bit            m_has_grant = 1'b0;
    bit            m_in_hold  = 1'b0;
    int            m_age      = 0;
    int            m_next_pri = 0;
    logic [NP-1:0] m_conf     = '0;
    int            m_grants   = 0;
    int            m_conflicts = 0;
    int            m_timeouts = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // True when another processor's table holds the owner's key as a live entry.
    function automatic bit ref_conflict(input int own);
        logic [31:0] others [$];
        for (int p = 0; p < NP; p++) begin
            if (p != own) begin
                for (int k = 0; k < NK; k++) begin
                    if (tab[p][k] != 32'hFFFF_FFFF) others.push_back(tab[p][k]);
                end
            end
        end
        foreach (others[i]) begin
            if (others[i] == key[own]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [NP-1:0] m_grant_vec();
        logic [NP-1:0] g;
        g = '0;
        if (m_has_grant) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_step();
        int best;
        int bestd;
        int d;
        if (!reset_n) begin
            m_owner = -1; m_has_grant = 1'b0; m_in_hold = 1'b0; m_age = 0; m_next_pri = 0;
            m_conf = '0; m_grants = 0; m_conflicts = 0; m_timeouts = 0;
        end else if (m_has_grant) begin
            if (snoop_check_req[m_owner]) begin
                m_conf = '0;
                m_conf[m_owner] = ref_conflict(m_owner);
                if (m_conf != '0) m_conflicts++;
                m_has_grant = 1'b0;
                m_in_hold = 1'b1;
            end else if (m_age == TO - 1) begin
                m_has_grant = 1'b0;
                m_next_pri = (m_owner + 1) % NP;
                m_owner = -1;
                m_timeouts++;
            end else begin
                m_age++;
            end
        end else if (m_in_hold) begin
            if (bus_release[m_owner]) begin
                m_conf = '0;
                m_in_hold = 1'b0;
                m_next_pri = (m_owner + 1) % NP;
                m_owner = -1;
            end
        end else begin
            best = -1;
            bestd = NP;
            for (int p = 0; p < NP; p++) begin
                d = (p - m_next_pri + NP) % NP;
                if (bus_request[p] && d < bestd) begin
                    best = p;
                    bestd = d;
                end
            end
            if (best >= 0) begin
                m_owner = best; m_has_grant = 1'b1; m_age = 0; m_grants++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("cycle", 32'({bus_grant, add_conflict}), 32'({m_grant_vec(), m_conf}));
`ifdef SNOOPY_ARB_STATS_EN
        check("stat_grants", stat_grants, 32'(m_grants));
        check("stat_conflicts", stat_conflicts, 32'(m_conflicts));
        check("stat_timeouts", 32'(stat_timeouts), 32'(m_timeouts));
`endif
    endtask

    task automatic clear_inputs();
        bus_request = '0;
        bus_release = '0;
        snoop_check_req = '0;
        for (int p = 0; p < NP; p++) begin
            key[p] = '0;
            for (int k = 0; k < NK; k++) tab[p][k] = 32'hFFFF_FFFF;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        tick();
        reset_n = 1'b1;
    endtask

    typedef struct {
        int          pid;
        logic [31:0] vkey;
        int          tproc;
        int          tent;
        logic [31:0] tval;
        logic        exp_conf;
    } vec_t;

    initial begin
        vec_t vecs [6];
        int   rr_exp [4];
        int   idx;
        int   cnt;

        vecs[0] = '{pid: 1, vkey: 32'h10,        tproc: -1, tent: 0, tval: 32'h0,        exp_conf: 1'b0};
        vecs[1] = '{pid: 0, vkey: 32'h10,        tproc: 2,  tent: 0, tval: 32'h10,       exp_conf: 1'b1};
        vecs[2] = '{pid: 0, vkey: 32'h10,        tproc: 0,  tent: 0, tval: 32'h10,       exp_conf: 1'b0};
        vecs[3] = '{pid: 3, vkey: 32'hFFFF_FFFF, tproc: -1, tent: 0, tval: 32'h0,        exp_conf: 1'b0};
        vecs[4] = '{pid: 2, vkey: 32'hDEAD_BEEF, tproc: 3,  tent: 3, tval: 32'hDEAD_BEEF, exp_conf: 1'b1};
        vecs[5] = '{pid: 1, vkey: 32'h11,        tproc: 0,  tent: 1, tval: 32'h10,       exp_conf: 1'b0};
        rr_exp = '{0, 1, 3, 0};
        pool = '{32'h10, 32'h20, 32'h30, 32'hFFFF_FFFF, 32'h10};

        reset_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        check("reset grant", 32'(bus_grant), 32'h0);
        check("reset conflict", 32'(add_conflict), 32'h0);
        reset_n = 1'b1;
        tick();

        // Compare vectors: grant at T, strobe at T+1, result at T+2 held until release.
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            if (vecs[i].tproc >= 0) tab[vecs[i].tproc][vecs[i].tent] = vecs[i].tval;
            key[vecs[i].pid] = vecs[i].vkey;
            bus_request[vecs[i].pid] = 1'b1;
            tick();
            check("vec grant", 32'(bus_grant), 32'(1) << vecs[i].pid);
            tick();
            snoop_check_req[vecs[i].pid] = 1'b1;
            tick();
            snoop_check_req = '0;
            bus_request = '0;
            check("vec grant drop", 32'(bus_grant), 32'h0);
            check("vec conflict", 32'(add_conflict), 32'(vecs[i].exp_conf) << vecs[i].pid);
            tick();
            tick();
            check("vec conflict held", 32'(add_conflict), 32'(vecs[i].exp_conf) << vecs[i].pid);
            bus_release[vecs[i].pid] = 1'b1;
            tick();
            bus_release = '0;
            check("vec released", 32'(add_conflict), 32'h0);
            tick();
        end

        // Round robin among procs 0, 1, 3 holding requests.
        do_reset();
        bus_request = 4'b1011;
        for (int t = 0; t < 4; t++) begin
            for (int c = 0; c < 10 && bus_grant == '0; c++) tick();
            idx = -1;
            for (int p = 0; p < NP; p++) if (bus_grant[p]) idx = p;
            check("rr order", 32'(idx), 32'(rr_exp[t]));
            check("rr onehot", 32'($countones(bus_grant)), 32'd1);
            if (idx < 0) break;
            tick();
            snoop_check_req[idx] = 1'b1;
            tick();
            snoop_check_req = '0;
            bus_release[idx] = 1'b1;
            tick();
            bus_release = '0;
        end
        bus_request = '0;
        tick();

        // Timeout: proc2 never strobes; proc3 waits.
        do_reset();
        bus_request = 4'b1100;
        tick();
        check("to first grant", 32'(bus_grant), 32'h4);
        cnt = 1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus_grant[2]) cnt++;
            else break;
        end
        check("to grant length", 32'(cnt), 32'(TO));
        tick();
        check("to next owner", 32'(bus_grant), 32'h8);
`ifdef SNOOPY_ARB_STATS_EN
        check("to stat", 32'(stat_timeouts), 32'd1);
`endif

        // Reset during HOLD clears outputs and the round-robin pointer.
        do_reset();
        tab[2][0] = 32'h10;
        key[1] = 32'h10;
        bus_request = 4'b0001;
        tick();
        tick();
        snoop_check_req[0] = 1'b1;
        tick();
        snoop_check_req = '0;
        bus_request = '0;
        bus_release[0] = 1'b1;
        tick();
        bus_release = '0;
        bus_request = 4'b0010;
        tick();
        check("hr grant1", 32'(bus_grant), 32'h2);
        tick();
        snoop_check_req[1] = 1'b1;
        tick();
        snoop_check_req = '0;
        bus_request = '0;
        check("hr hold conflict", 32'(add_conflict), 32'h2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("hr reset grant", 32'(bus_grant), 32'h0);
        check("hr reset conflict", 32'(add_conflict), 32'h0);
        bus_request = 4'b0011;
        tick();
        check("hr rr restart", 32'(bus_grant), 32'h1);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int p = 0; p < NP; p++) begin
                bus_request[p] = ($urandom_range(0, 3) != 0);
                bus_release[p] = ($urandom_range(0, 3) == 0);
                snoop_check_req[p] = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 7) == 0) key[p] = pool[$urandom_range(0, 3)];
            end
            if (c % 16 == 0) begin
                for (int p = 0; p < NP; p++) begin
                    for (int k = 0; k < NK; k++) tab[p][k] = pool[$urandom_range(0, 4)];
                end
            end
            reset_n = ($urandom_range(0, 249) != 0);
            tick();
        end
        reset_n = 1'b1;
        clear_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
